// File: rtl/f_pred_pc_unit.sv
// Fetch-stage next-PC predictor: bimodal 2-bit BHT for jXX, circular return-address
// stack for call/ret, and a redirect path that loads the corrected PC.
module f_pred_pc_unit #(
  parameter int unsigned WIDTH     = 48,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned MODE      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             F_stall_i,
  input  logic [WIDTH-1:0] f_pc_i,
  input  logic [3:0]       f_icode_i,
  input  logic [WIDTH-1:0] f_valC_i,
  input  logic [WIDTH-1:0] f_valP_i,
  input  logic             E_upd_i,
  input  logic [WIDTH-1:0] E_upd_pc_i,
  input  logic             E_taken_i,
  input  logic             M_redirect_i,
  input  logic [WIDTH-1:0] M_target_i,
  output logic [WIDTH-1:0] F_predPC_o,
  output logic             F_predTaken_o,
  output logic             F_rasEmpty_o
);

  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  localparam int IDX = $clog2(BHT_DEPTH);
  localparam int PW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW  = $clog2(RAS_DEPTH + 1);

  logic [1:0]       bht [BHT_DEPTH];
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [CW-1:0]    ras_cnt;

  logic [IDX-1:0]   f_idx;
  logic [IDX-1:0]   upd_idx;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             jxx_bit;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] pc_next;
  logic             tk_next;
  logic             unused_pc_bits;

  assign f_idx          = f_pc_i[IDX-1:0];
  assign upd_idx        = E_upd_pc_i[IDX-1:0];
  assign unused_pc_bits = ^{f_pc_i[WIDTH-1:IDX], E_upd_pc_i[WIDTH-1:IDX]};

  // ras_ptr names the next free slot; the top of stack sits one below it.
  assign ptr_inc   = (ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;
  assign ptr_dec   = (ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
  assign ras_top   = ras_mem[ptr_dec];
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
  assign jxx_bit   = (MODE == 0) ? 1'b1 : bht[f_idx][1];

  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    pc_next = F_predPC_o;
    tk_next = F_predTaken_o;
    if (M_redirect_i) begin
      pc_next = M_target_i;
      tk_next = 1'b0;
    end else if (!F_stall_i) begin
      tk_next = 1'b0;
      case (f_icode_i)
        IJXX: begin
          if (jxx_bit) begin
            pc_next = f_valC_i;
            tk_next = 1'b1;
          end else begin
            pc_next = f_valP_i;
          end
        end
        ICALL: begin
          pc_next = f_valC_i;
          push    = 1'b1;
        end
        IRET: begin
          // An empty stack falls through; the pipeline's ret bubble covers it.
          if (ras_empty) begin
            pc_next = f_valP_i;
          end else begin
            pc_next = ras_top;
            pop     = 1'b1;
          end
        end
        default: pc_next = f_valP_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      F_predPC_o    <= '0;
      F_predTaken_o <= 1'b0;
      ras_ptr       <= '0;
      ras_cnt       <= '0;
    end else begin
      F_predPC_o    <= pc_next;
      F_predTaken_o <= tk_next;
      if (push) begin
        ras_ptr <= ptr_inc;
        if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop) begin
        ras_ptr <= ptr_dec;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  // Stack storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= f_valP_i;
  end

  // Training runs even while fetch is stalled or redirected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b10;
    end else if (E_upd_i) begin
      if (E_taken_i) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  assign F_rasEmpty_o = ras_empty;

endmodule
